// File: rtl/vga_sync_rx_pkg.sv
// Shared VGA timing constants, lock-FSM encoding and small arithmetic helpers
// for the VGA receive path.
package vga_sync_rx_pkg;

  localparam int unsigned X_W         = 10;
  localparam int unsigned LEN_W       = 11;

  localparam int unsigned H_TOTAL     = 800;
  localparam int unsigned V_TOTAL     = 525;
  localparam int unsigned H_SYNC      = 96;
  localparam int unsigned V_SYNC      = 2;
  localparam int unsigned H_ACT_START = 144;
  localparam int unsigned H_ACT_END   = 784;
  localparam int unsigned V_ACT_START = 35;
  localparam int unsigned V_ACT_END   = 515;
  localparam int unsigned LOCK_LINES  = 4;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_HLOCK    = 2'd1,
    ST_VSEEN    = 2'd2,
    ST_LOCKED   = 2'd3
  } lock_state_e;

  // Counters stick at all-ones instead of wrapping so a dead sync never aliases.
  function automatic logic [X_W-1:0] sat_inc(input logic [X_W-1:0] v);
    return (v == 10'd1023) ? v : v + 10'd1;
  endfunction

  function automatic logic [LEN_W-1:0] len_of(input logic [X_W-1:0] v);
    return {1'b0, v} + 11'd1;
  endfunction

endpackage

// File: rtl/vga_sync_rx_if.sv
// VGA receive bus: raw timing inputs from the generator side and the
// recovered coordinates / lock status returned by the receiver.
interface vga_sync_rx_if;
  import vga_sync_rx_pkg::*;

  logic             VGA_CLK;
  logic             VGA_HS;
  logic             VGA_VS;
  logic [X_W-1:0]   x;
  logic [X_W-1:0]   y;
  logic             ativo;
  logic             locked;
  logic             frame_start;
  logic             sync_err;
  logic [LEN_W-1:0] line_len;

  modport master (
    output VGA_CLK, VGA_HS, VGA_VS,
    input  x, y, ativo, locked, frame_start, sync_err, line_len
  );

  modport slave (
    input  VGA_CLK, VGA_HS, VGA_VS,
    output x, y, ativo, locked, frame_start, sync_err, line_len
  );

endinterface

// File: rtl/vga_sync_rx_sampler.sv
// Samples the pixel clock and sync lines as data in the system clock domain and
// produces single-cycle tick / sync-falling-edge strobes.
module vga_sync_rx_sampler (
  input  logic clk_i,
  input  logic rst_i,
  input  logic vga_clk_i,
  input  logic vga_hs_i,
  input  logic vga_vs_i,
  output logic tick_o,
  output logic hs_fall_o,
  output logic vs_fall_o
);

  logic clk_q;
  logic hs_q;
  logic vs_q;

  assign tick_o    = vga_clk_i & ~clk_q;
  // Sync levels are only compared against the previous pixel, not the previous system cycle.
  assign hs_fall_o = tick_o & ~vga_hs_i & hs_q;
  assign vs_fall_o = tick_o & ~vga_vs_i & vs_q;

  // Edge-detect history; syncs idle high so reset to 1 to avoid a false fall.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_q <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      clk_q <= vga_clk_i;
      if (tick_o) begin
        hs_q <= vga_hs_i;
        vs_q <= vga_vs_i;
      end else begin
        hs_q <= hs_q;
        vs_q <= vs_q;
      end
    end
  end

endmodule

// File: rtl/vga_sync_rx.sv
// VGA timing receiver: recovers x/y from HS/VS, measures line/frame lengths
// and runs the lock FSM (lines first, then two consistent frame boundaries).
module vga_sync_rx
  import vga_sync_rx_pkg::*;
#(
  parameter int unsigned P_H_TOTAL     = H_TOTAL,
  parameter int unsigned P_V_TOTAL     = V_TOTAL,
  parameter int unsigned P_H_ACT_START = H_ACT_START,
  parameter int unsigned P_H_ACT_END   = H_ACT_END,
  parameter int unsigned P_V_ACT_START = V_ACT_START,
  parameter int unsigned P_V_ACT_END   = V_ACT_END,
  parameter int unsigned P_LOCK_LINES  = LOCK_LINES
) (
  input logic          CLOCK_50,
  input logic          reset,
  vga_sync_rx_if.slave vga
);

  logic tick_s;
  logic hs_fall_s;
  logic vs_fall_s;

  vga_sync_rx_sampler u_sampler (
    .clk_i     (CLOCK_50),
    .rst_i     (reset),
    .vga_clk_i (vga.VGA_CLK),
    .vga_hs_i  (vga.VGA_HS),
    .vga_vs_i  (vga.VGA_VS),
    .tick_o    (tick_s),
    .hs_fall_o (hs_fall_s),
    .vs_fall_o (vs_fall_s)
  );

  logic [X_W-1:0]   x_q, x_d;
  logic [X_W-1:0]   y_q, y_d;
  logic [LEN_W-1:0] line_len_q, line_len_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;
  logic             vs_pend_q, vs_pend_d;
  logic [7:0]       good_cnt_q, good_cnt_d;
  lock_state_e      state_q, state_d;
  logic             locked_q;
  logic             frame_start_q, frame_start_d;
  logic             sync_err_q, sync_err_d;

  logic [LEN_W-1:0] x_len_s;
  logic             good_s;
  logic             timeout_s;
  logic             bad_s;
  logic             boundary_s;

  assign x_len_s    = len_of(x_q);
  assign good_s     = hs_fall_s & (x_len_s == 11'(P_H_TOTAL));
  // Timeout fires only on the tick that lands on 1023, so it is reported once.
  assign timeout_s  = tick_s & ~hs_fall_s & (x_q == 10'd1022);
  assign bad_s      = (hs_fall_s & ~good_s) | timeout_s;
  // A VS fall mid-line is held in vs_pend and committed at the next HS fall.
  assign boundary_s = hs_fall_s & (vs_pend_q | vs_fall_s);

  // Coordinate counters, measured lengths and pending-VS flag.
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    line_len_d  = line_len_q;
    frame_len_d = frame_len_q;
    vs_pend_d   = vs_pend_q;
    if (tick_s) begin
      if (hs_fall_s) begin
        x_d        = 10'd0;
        line_len_d = x_len_s;
        if (boundary_s) begin
          y_d         = 10'd0;
          frame_len_d = len_of(y_q);
          vs_pend_d   = 1'b0;
        end else begin
          y_d = sat_inc(y_q);
        end
      end else begin
        x_d       = sat_inc(x_q);
        vs_pend_d = vs_pend_q | vs_fall_s;
      end
    end else begin
      x_d = x_q;
    end
  end

  // Lock FSM next state and the single-cycle status pulses.
  always_comb begin
    state_d       = state_q;
    good_cnt_d    = good_cnt_q;
    frame_start_d = 1'b0;
    sync_err_d    = 1'b0;
    if (tick_s) begin
      case (state_q)
        ST_UNLOCKED: begin
          if (bad_s) begin
            good_cnt_d = 8'd0;
          end else if (good_s) begin
            if ((good_cnt_q + 8'd1) >= 8'(P_LOCK_LINES)) begin
              state_d    = ST_HLOCK;
              good_cnt_d = 8'd0;
            end else begin
              good_cnt_d = good_cnt_q + 8'd1;
            end
          end else begin
            good_cnt_d = good_cnt_q;
          end
        end
        ST_HLOCK: begin
          if (bad_s) begin
            state_d    = ST_UNLOCKED;
            good_cnt_d = 8'd0;
          end else if (boundary_s) begin
            state_d = ST_VSEEN;
          end else begin
            state_d = ST_HLOCK;
          end
        end
        ST_VSEEN: begin
          if (bad_s) begin
            state_d    = ST_UNLOCKED;
            good_cnt_d = 8'd0;
          end else if (boundary_s) begin
            if (frame_len_d == 11'(P_V_TOTAL)) begin
              state_d = ST_LOCKED;
            end else begin
              state_d    = ST_UNLOCKED;
              good_cnt_d = 8'd0;
            end
          end else begin
            state_d = ST_VSEEN;
          end
        end
        ST_LOCKED: begin
          if (bad_s || (boundary_s && (frame_len_d != 11'(P_V_TOTAL)))) begin
            state_d    = ST_UNLOCKED;
            good_cnt_d = 8'd0;
            sync_err_d = 1'b1;
          end else if (boundary_s) begin
            frame_start_d = 1'b1;
          end else begin
            state_d = ST_LOCKED;
          end
        end
        default: begin
          state_d    = ST_UNLOCKED;
          good_cnt_d = 8'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers; reset overrides any tick in the same cycle.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      line_len_q    <= 11'd0;
      frame_len_q   <= 11'd0;
      vs_pend_q     <= 1'b0;
      good_cnt_q    <= 8'd0;
      state_q       <= ST_UNLOCKED;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      line_len_q    <= line_len_d;
      frame_len_q   <= frame_len_d;
      vs_pend_q     <= vs_pend_d;
      good_cnt_q    <= good_cnt_d;
      state_q       <= state_d;
      locked_q      <= (state_d == ST_LOCKED);
      frame_start_q <= frame_start_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.line_len    = line_len_q;
  assign vga.locked      = locked_q;
  assign vga.frame_start = frame_start_q;
  assign vga.sync_err    = sync_err_q;
  assign vga.ativo       = locked_q
                         & (x_q >= 10'(P_H_ACT_START)) & (x_q < 10'(P_H_ACT_END))
                         & (y_q >= 10'(P_V_ACT_START)) & (y_q < 10'(P_V_ACT_END));

endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx: a scaled-down VGA generator drives the receiver with
// randomized disturbances; a tick-level reference model feeds a scoreboard.
module tb_vga_sync_rx;

  localparam int H     = 40;
  localparam int V     = 16;
  localparam int HA0   = 8;
  localparam int HA1   = 36;
  localparam int VA0   = 3;
  localparam int VA1   = 14;
  localparam int LOCKN = 4;
  localparam int HSW   = 4;
  localparam int VSL   = 2;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;

  vga_sync_rx_if vga();

  vga_sync_rx #(
    .P_H_TOTAL(H), .P_V_TOTAL(V),
    .P_H_ACT_START(HA0), .P_H_ACT_END(HA1),
    .P_V_ACT_START(VA0), .P_V_ACT_END(VA1),
    .P_LOCK_LINES(LOCKN)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .vga      (vga)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [10:0] len;
    logic        lk;
    logic        av;
    logic        fs;
    logic        se;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: counts since last HS fall / frame boundary, plus lock stage
  // 0=searching lines, 1=lines ok, 2=one boundary seen, 3=locked.
  int m_x, m_y, m_len, m_flen, m_stage, m_streak;
  bit m_pend, m_hs_prev, m_vs_prev;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_len = 0; m_flen = 0; m_stage = 0; m_streak = 0;
    m_pend = 1'b0; m_hs_prev = 1'b1; m_vs_prev = 1'b1;
  endtask

  task automatic model_step(input logic hs, input logic vs);
    bit   hf, vf, good, bad, bnd;
    int   was;
    exp_t e;
    hf = !hs && m_hs_prev;
    vf = !vs && m_vs_prev;
    m_hs_prev = hs;
    m_vs_prev = vs;
    good = 1'b0; bad = 1'b0; bnd = 1'b0;
    if (hf) begin
      m_len = m_x + 1;
      good  = (m_len == H);
      bad   = !good;
      m_x   = 0;
      if (m_pend || vf) begin
        bnd = 1'b1; m_flen = m_y + 1; m_y = 0; m_pend = 1'b0;
      end else begin
        m_y = (m_y < 1023) ? m_y + 1 : 1023;
      end
    end else begin
      bad = (m_x == 1022);
      m_x = (m_x < 1023) ? m_x + 1 : 1023;
      if (vf) m_pend = 1'b1;
    end
    e.fs = 1'b0;
    e.se = 1'b0;
    was = m_stage;
    case (m_stage)
      0: if (good) begin
           m_streak++;
           if (m_streak >= LOCKN) m_stage = 1;
         end else if (bad) m_streak = 0;
      1: if (bad) m_stage = 0; else if (bnd) m_stage = 2;
      2: if (bad) m_stage = 0; else if (bnd) m_stage = (m_flen == V) ? 3 : 0;
      default: if (bad || (bnd && m_flen != V)) begin
                 m_stage = 0; e.se = 1'b1;
               end else if (bnd) e.fs = 1'b1;
    endcase
    if (m_stage == 0 && was != 0) m_streak = 0;
    e.x   = 10'(m_x);
    e.y   = 10'(m_y);
    e.len = 11'(m_len);
    e.lk  = (m_stage == 3);
    e.av  = e.lk && m_x >= HA0 && m_x < HA1 && m_y >= VA0 && m_y < VA1;
    sbq.push_back(e);
  endtask

  // One pixel: VGA_CLK high for one system cycle, low for the next.
  task automatic pixel(input logic hs, input logic vs);
    @(negedge CLOCK_50);
    vga.VGA_CLK = 1'b1;
    vga.VGA_HS  = hs;
    vga.VGA_VS  = vs;
    model_step(hs, vs);
    @(negedge CLOCK_50);
    vga.VGA_CLK = 1'b0;
  endtask

  // Frame of nlines lines; one line may get length bad_len; VS low window starts at tick vs_off.
  task automatic frame(input int nlines, input int bad_idx, input int bad_len, input int vs_off);
    int pos, len;
    pos = 0;
    for (int l = 0; l < nlines; l++) begin
      len = (l == bad_idx) ? bad_len : H;
      for (int i = 0; i < len; i++) begin
        pixel((i < HSW) ? 1'b0 : 1'b1,
              (pos >= vs_off && pos < vs_off + VSL * H) ? 1'b0 : 1'b1);
        pos++;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_x"},           32'(vga.x), 32'd0);
    chk({tag, "_y"},           32'(vga.y), 32'd0);
    chk({tag, "_line_len"},    32'(vga.line_len), 32'd0);
    chk({tag, "_locked"},      32'(vga.locked), 32'd0);
    chk({tag, "_ativo"},       32'(vga.ativo), 32'd0);
    chk({tag, "_frame_start"}, 32'(vga.frame_start), 32'd0);
    chk({tag, "_sync_err"},    32'(vga.sync_err), 32'd0);
  endtask

  // Monitor: after every system edge, compare the DUT against the next expected
  // record on pixel ticks; between ticks the pulses must be low.
  logic mon_clk_prev = 1'b0;
  initial begin
    logic tk, rs;
    exp_t e;
    forever begin
      @(posedge CLOCK_50);
      rs = reset;
      tk = vga.VGA_CLK & ~mon_clk_prev;
      mon_clk_prev = rs ? 1'b0 : vga.VGA_CLK;
      #1;
      if (!rs) begin
        if (tk) begin
          if (sbq.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
          end else begin
            e = sbq.pop_front();
            chk("x",           32'(vga.x), 32'(e.x));
            chk("y",           32'(vga.y), 32'(e.y));
            chk("line_len",    32'(vga.line_len), 32'(e.len));
            chk("locked",      32'(vga.locked), 32'(e.lk));
            chk("ativo",       32'(vga.ativo), 32'(e.av));
            chk("frame_start", 32'(vga.frame_start), 32'(e.fs));
            chk("sync_err",    32'(vga.sync_err), 32'(e.se));
          end
        end else begin
          chk("frame_start_idle", 32'(vga.frame_start), 32'd0);
          chk("sync_err_idle",    32'(vga.sync_err), 32'd0);
        end
      end
    end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, badlen;
    vga.VGA_CLK = 1'b0;
    vga.VGA_HS  = 1'b1;
    vga.VGA_VS  = 1'b1;
    model_reset();
    repeat (3) @(negedge CLOCK_50);
    check_reset_outputs("por");
    reset = 1'b0;

    // Lock acquisition: bad first line, LOCK_LINES good lines, then two boundaries.
    repeat (3) frame(V, -1, 0, 0);
    chk("lock_after_3_frames", 32'(vga.locked), 32'd1);

    for (int k = 0; k < 8; k++) begin
      sel = k % 6;
      case (sel)
        0: begin
          badlen = (k == 0) ? H - 1 : H + int'($urandom_range(1, 5)) - 6 * int'($urandom_range(0, 1));
          frame(V, int'($urandom_range(3, V - 2)), badlen, 0);
        end
        1: for (int i = 0; i < 1100; i++) pixel(1'b1, 1'b1);
        2: frame(V - 1, -1, 0, 0);
        3: begin
          frame(int'($urandom_range(2, V - 2)), -1, 0, 0);
          reset = 1'b1;
          @(posedge CLOCK_50);
          #1;
          check_reset_outputs("midreset");
          @(negedge CLOCK_50);
          reset = 1'b0;
          model_reset();
        end
        4: frame(V, -1, 0, int'($urandom_range(5, H - 5)));
        default: repeat (int'($urandom_range(1, 2))) frame(V, -1, 0, 0);
      endcase
      repeat (3) frame(V, -1, 0, 0);
      chk("relock", 32'(vga.locked), 32'd1);
    end

    repeat (4) @(negedge CLOCK_50);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
